alu_booth_mul_32: RTL and testbench

Sequential radix-2 Booth multiplier that drives the shared 32-bit ripple adder (`Alu_Add_32`) for one partial-product step per clock. It sits directly upstream of that adder: it feeds the adder's operand and carry-in ports and consumes its sum and carry-out. It produces a signed 64-bit product for the datapath's ZHigh/ZLow result registers on behalf of the MUL instruction.

---
 rtl/alu_booth_mul_32.sv | 152 +++++++++++++++
 tb/tb_alu_booth_mul_32.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_booth_mul_32.sv
// Sequential radix-2 Booth multiplier driving an external combinational adder, one step per clock.
// Optional `ovf` output (product does not fit in WIDTH bits) is enabled by defining ALU_MUL_OVF_EN.
module alu_booth_mul_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_cout,
   output logic             busy,
   output logic             done,
`ifdef ALU_MUL_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] ZHigh,
   output logic [WIDTH-1:0] ZLow
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q1_q, q1_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] zhi_q, zhi_d;
   logic [WIDTH-1:0] zlo_q, zlo_d;
   logic             last;
   logic             sgn;
`ifdef ALU_MUL_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign last = (cnt_q == 6'(WIDTH - 1));

   // State register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last)  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: status and adder control
   always_comb begin
      busy    = (state_q == S_RUN);
      done    = (state_q == S_DONE);
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         case ({q_q[0], q1_q})
            2'b01:   add_b = m_q;
            2'b10: begin
               add_b   = ~m_q;
               add_cin = 1'b1;
            end
            default: add_b = '0;
         endcase
      end
   end

   assign add_a = a_q;
   assign ZHigh = zhi_q;
   assign ZLow  = zlo_q;

   // Sign of the full (WIDTH+1)-bit sum, so A - 0x80000000 cannot overflow the shift.
   assign sgn = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

   always_comb begin
      m_d   = m_q;
      a_d   = a_q;
      q_d   = q_q;
      q1_d  = q1_q;
      cnt_d = cnt_q;
      zhi_d = zhi_q;
      zlo_d = zlo_q;
`ifdef ALU_MUL_OVF_EN
      ovf_d = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d   = Ra;
               q_d   = Rb;
               a_d   = '0;
               q1_d  = 1'b0;
               cnt_d = '0;
            end
         end
         S_RUN: begin
            a_d   = {sgn, add_s[WIDTH-1:1]};
            q_d   = {add_s[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + 6'd1;
            if (last) begin
               zhi_d = a_d;
               zlo_d = q_d;
`ifdef ALU_MUL_OVF_EN
               ovf_d = (a_d != {WIDTH{q_d[WIDTH-1]}});
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_q   <= '0;
         a_q   <= '0;
         q_q   <= '0;
         q1_q  <= 1'b0;
         cnt_q <= '0;
         zhi_q <= '0;
         zlo_q <= '0;
      end else begin
         m_q   <= m_d;
         a_q   <= a_d;
         q_q   <= q_d;
         q1_q  <= q1_d;
         cnt_q <= cnt_d;
         zhi_q <= zhi_d;
         zlo_q <= zlo_d;
      end
   end

`ifdef ALU_MUL_OVF_EN
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_booth_mul_32.sv
// Randomized self-checking bench for alu_booth_mul_32; models the external adder and
// compares results against a plain signed 64-bit multiply.
module tb_alu_booth_mul_32;

   logic        clock = 1'b0;
   logic        clear_n;
   logic        start;
   logic [31:0] Ra, Rb;
   logic [31:0] add_a, add_b, add_s;
   logic        add_cin, add_cout;
   logic        busy, done;
   logic [31:0] ZHigh, ZLow;
`ifdef ALU_MUL_OVF_EN
   logic        ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   // Behavioural stand-in for the shared ripple adder
   always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   alu_booth_mul_32 #(.WIDTH(32)) dut (
      .clock    (clock),
      .clear_n  (clear_n),
      .start    (start),
      .Ra       (Ra),
      .Rb       (Rb),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
`ifdef ALU_MUL_OVF_EN
      .ovf      (ovf),
`endif
      .ZHigh    (ZHigh),
      .ZLow     (ZLow)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
   endfunction

   // Wait (bounded) for done; returns cycles elapsed since the caller's accepting edge offset.
   task automatic wait_done(input int already, output int cyc);
      cyc = already;
      while (!done && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
      end
   endtask

   // Called at #1 after a posedge with the DUT idle; returns at #1 after T33.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int cyc;
      p = ref_mul(a, b);
      Ra = a; Rb = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      Ra = $urandom; Rb = $urandom;
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
      wait_done(0, cyc);
      chk("latency", 64'(cyc), 64'd32);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      chk("product", {ZHigh, ZLow}, p);
`ifdef ALU_MUL_OVF_EN
      chk("ovf", {63'd0, ovf}, {63'd0, (p[63:32] != {32{p[31]}})});
`endif
      @(posedge clock); #1;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("product_hold", {ZHigh, ZLow}, p);
   endtask

   initial begin
      int cyc;
      int dones;
      logic [31:0] ra, rb;
      clear_n = 1'b0; start = 1'b0; Ra = '0; Rb = '0;
      #12;
      chk("rst_busy",  {63'd0, busy},    64'd0);
      chk("rst_done",  {63'd0, done},    64'd0);
      chk("rst_z",     {ZHigh, ZLow},    64'd0);
      chk("rst_add_a", {32'd0, add_a},   64'd0);
      chk("rst_add_b", {32'd0, add_b},   64'd0);
      chk("rst_cin",   {63'd0, add_cin}, 64'd0);
`ifdef ALU_MUL_OVF_EN
      chk("rst_ovf",   {63'd0, ovf},     64'd0);
`endif
      clear_n = 1'b1;
      @(posedge clock); #1;

      run_mul(32'd6, 32'd7);
      chk("dir_6x7", {ZHigh, ZLow}, 64'h0000_0000_0000_002A);
      run_mul(32'hFFFF_FFFD, 32'd5);
      chk("dir_m3x5", {ZHigh, ZLow}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_mul(32'h8000_0000, 32'h8000_0000);
      chk("dir_min_min", {ZHigh, ZLow}, 64'h4000_0000_0000_0000);
      run_mul(32'h8000_0000, 32'd1);
      chk("dir_min_1", {ZHigh, ZLow}, 64'hFFFF_FFFF_8000_0000);
      run_mul(32'h0001_0000, 32'h0001_0000);
      chk("dir_2p32", {ZHigh, ZLow}, 64'h0000_0001_0000_0000);
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("dir_m1_m1", {ZHigh, ZLow}, 64'h0000_0000_0000_0001);
      run_mul(32'h7FFF_FFFF, 32'h8000_0000);

      // start while busy must be ignored
      Ra = 32'd3; Rb = 32'd4; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clock); #1; end
      Ra = 32'd9; Rb = 32'd9; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(10, cyc);
      chk("ign_latency", 64'(cyc), 64'd32);
      chk("ign_result", {ZHigh, ZLow}, 64'h0000_0000_0000_000C);
      @(posedge clock); #1;
      run_mul(32'd9, 32'd9);
      chk("after_ign", {ZHigh, ZLow}, 64'h0000_0000_0000_0051);

      // reset in mid-operation
      Ra = 32'd6; Rb = 32'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clock); #1; end
      clear_n = 1'b0;
      #1;
      chk("mid_rst_busy",  {63'd0, busy},    64'd0);
      chk("mid_rst_done",  {63'd0, done},    64'd0);
      chk("mid_rst_z",     {ZHigh, ZLow},    64'd0);
      chk("mid_rst_add_a", {32'd0, add_a},   64'd0);
      chk("mid_rst_add_b", {32'd0, add_b},   64'd0);
      chk("mid_rst_cin",   {63'd0, add_cin}, 64'd0);
      #1 clear_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done || busy) dones++;
      end
      chk("no_done_after_rst", 64'(dones), 64'd0);

      // randomized operands with a bias toward corner values
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: ra = 32'h8000_0000;
            1: ra = 32'(int'($urandom_range(0, 6)) - 3);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: rb = 32'h7FFF_FFFF;
            1: rb = 32'(int'($urandom_range(0, 6)) - 3);
            default: rb = $urandom;
         endcase
         run_mul(ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
